// File: rtl/glb_bank_ctrl_if.sv
// Switch-side packet interface of one bank controller: the bank-steered
// write and read-request packets in, and the read-response packet out.
interface glb_bank_ctrl_if #(
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int BANK_DATA_WIDTH = 64
);
    logic                         wr_en;
    logic [BANK_DATA_WIDTH/8-1:0] wr_strb;
    logic [BANK_ADDR_WIDTH-1:0]   wr_addr;
    logic [BANK_DATA_WIDTH-1:0]   wr_data;
    logic                         rd_en;
    logic [BANK_ADDR_WIDTH-1:0]   rd_addr;
    logic [BANK_DATA_WIDTH-1:0]   rd_data;
    logic                         rd_data_valid;
    logic                         wr_overflow;

    // Switch side: issues packets, receives responses.
    modport master (
        output wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_data_valid, wr_overflow
    );

    // Bank controller side.
    modport slave (
        input  wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_data_valid, wr_overflow
    );
endinterface

// File: rtl/glb_bank_ctrl.sv
// Per-bank controller: registers switch packets (S0), performs one SRAM
// access per cycle with read priority (S1), holds colliding writes in a
// small FIFO with byte-granular forwarding, and merges forwarded bytes with
// SRAM data (S2) to return read responses at a fixed 3-cycle latency.
module glb_bank_ctrl #(
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int WR_BUF_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    glb_bank_ctrl_if.slave             sw,
    output logic                       mem_cen,
    output logic                       mem_wen,
    output logic [BANK_ADDR_WIDTH-4:0] mem_addr,
    output logic [BANK_DATA_WIDTH-1:0] mem_data_in,
    output logic [BANK_DATA_WIDTH-1:0] mem_bit_mask,
    input  logic [BANK_DATA_WIDTH-1:0] mem_data_out
);
    localparam int unsigned STRB_W = BANK_DATA_WIDTH / 8;
    localparam int unsigned WORD_W = BANK_ADDR_WIDTH - 3;
    localparam int unsigned DEPTH  = WR_BUF_DEPTH;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Kind of SRAM access selected in S1.
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_DRAIN,
        ACC_BYPASS
    } acc_e;

    function automatic logic [BANK_DATA_WIDTH-1:0] expand_strb(input logic [STRB_W-1:0] strb);
        logic [BANK_DATA_WIDTH-1:0] bits;
        bits = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            bits[b*8 +: 8] = {8{strb[b]}};
        end
        return bits;
    endfunction

    // Byte offset bits do not take part in word selection.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, sw.wr_addr[2:0], sw.rd_addr[2:0]};

    // ---------------------------------------------------------------- S0
    logic                       s0_wr_vld;
    logic [WORD_W-1:0]          s0_wr_word;
    logic [STRB_W-1:0]          s0_wr_strb;
    logic [BANK_DATA_WIDTH-1:0] s0_wr_data;
    logic                       s0_rd_vld;
    logic [WORD_W-1:0]          s0_rd_word;

    // Input register; a write with no byte enabled is dropped here as a no-op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_wr_vld  <= 1'b0;
            s0_wr_word <= '0;
            s0_wr_strb <= '0;
            s0_wr_data <= '0;
            s0_rd_vld  <= 1'b0;
            s0_rd_word <= '0;
        end else begin
            s0_wr_vld  <= sw.wr_en && (sw.wr_strb != '0);
            s0_wr_word <= sw.wr_addr[BANK_ADDR_WIDTH-1:3];
            s0_wr_strb <= sw.wr_strb;
            s0_wr_data <= sw.wr_data;
            s0_rd_vld  <= sw.rd_en;
            s0_rd_word <= sw.rd_addr[BANK_ADDR_WIDTH-1:3];
        end
    end

    // ------------------------------------------------------ write buffer
    logic [WORD_W-1:0]          wb_word [DEPTH];
    logic [STRB_W-1:0]          wb_strb [DEPTH];
    logic [BANK_DATA_WIDTH-1:0] wb_data [DEPTH];
    logic [PTR_W-1:0]           wb_head;
    logic [PTR_W-1:0]           wb_tail;
    logic [CNT_W-1:0]           wb_count;
    logic                       overflow_q;

    acc_e acc;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // S1 arbitration: read first, then drain the buffer head, then bypass.
    // A bypass is only legal on an empty buffer so writes commit in order.
    always_comb begin
        acc     = ACC_IDLE;
        do_pop  = 1'b0;
        do_push = 1'b0;
        do_drop = 1'b0;
        if (s0_rd_vld) begin
            acc = ACC_READ;
        end else if (wb_count != '0) begin
            acc    = ACC_DRAIN;
            do_pop = 1'b1;
        end else if (s0_wr_vld) begin
            acc = ACC_BYPASS;
        end
        if (s0_wr_vld && (acc != ACC_BYPASS)) begin
            if ((wb_count == FULL_CNT) && !do_pop) begin
                do_drop = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end
    end

    // Buffer storage; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (do_push) begin
            wb_word[wb_tail] <= s0_wr_word;
            wb_strb[wb_tail] <= s0_wr_strb;
            wb_data[wb_tail] <= s0_wr_data;
        end
    end

    // Buffer occupancy tracking and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_head    <= '0;
            wb_tail    <= '0;
            wb_count   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_pop) begin
                wb_head <= wb_head + 1'b1;
            end
            if (do_push) begin
                wb_tail <= wb_tail + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   wb_count <= wb_count + 1'b1;
                2'b01:   wb_count <= wb_count - 1'b1;
                default: wb_count <= wb_count;
            endcase
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------- forwarding
    logic [STRB_W-1:0]          fwd_mask;
    logic [BANK_DATA_WIDTH-1:0] fwd_data;

    // Walk entries oldest to youngest, finishing with the S0 write, so the
    // youngest matching write owns each byte.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = wb_head;
        fwd_mask = '0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = wb_head + PTR_W'(i);
            if ((i < 32'(wb_count)) && (wb_word[idx] == s0_rd_word)) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wb_strb[idx][b]) begin
                        fwd_mask[b]        = 1'b1;
                        fwd_data[b*8 +: 8] = wb_data[idx][b*8 +: 8];
                    end
                end
            end
        end
        if (s0_wr_vld && (s0_wr_word == s0_rd_word)) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s0_wr_strb[b]) begin
                    fwd_mask[b]        = 1'b1;
                    fwd_data[b*8 +: 8] = s0_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------- SRAM port
    // Registered SRAM command for the access chosen in S1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_cen      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_bit_mask <= '0;
        end else begin
            mem_cen <= (acc != ACC_IDLE);
            mem_wen <= (acc == ACC_DRAIN) || (acc == ACC_BYPASS);
            case (acc)
                ACC_READ: begin
                    mem_addr     <= s0_rd_word;
                    mem_data_in  <= '0;
                    mem_bit_mask <= '0;
                end
                ACC_DRAIN: begin
                    mem_addr     <= wb_word[wb_head];
                    mem_data_in  <= wb_data[wb_head];
                    mem_bit_mask <= expand_strb(wb_strb[wb_head]);
                end
                ACC_BYPASS: begin
                    mem_addr     <= s0_wr_word;
                    mem_data_in  <= s0_wr_data;
                    mem_bit_mask <= expand_strb(s0_wr_strb);
                end
                default: begin
                    mem_addr     <= '0;
                    mem_data_in  <= '0;
                    mem_bit_mask <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------ read return
    logic                       p1_vld;
    logic [STRB_W-1:0]          p1_mask;
    logic [BANK_DATA_WIDTH-1:0] p1_data;
    logic                       p2_vld;
    logic [STRB_W-1:0]          p2_mask;
    logic [BANK_DATA_WIDTH-1:0] p2_data;
    logic [BANK_DATA_WIDTH-1:0] p2_bits;
    logic [BANK_DATA_WIDTH-1:0] merged;
    logic [BANK_DATA_WIDTH-1:0] rd_data_q;
    logic                       rd_valid_q;

    assign p2_bits = expand_strb(p2_mask);
    assign merged  = (p2_data & p2_bits) | (mem_data_out & ~p2_bits);

    // Forwarded bytes travel two stages so they meet mem_data_out, then merge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p1_vld     <= 1'b0;
            p1_mask    <= '0;
            p1_data    <= '0;
            p2_vld     <= 1'b0;
            p2_mask    <= '0;
            p2_data    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            p1_vld     <= (acc == ACC_READ);
            p1_mask    <= fwd_mask;
            p1_data    <= fwd_data;
            p2_vld     <= p1_vld;
            p2_mask    <= p1_mask;
            p2_data    <= p1_data;
            rd_valid_q <= p2_vld;
            rd_data_q  <= p2_vld ? merged : '0;
        end
    end

    assign sw.rd_data       = rd_data_q;
    assign sw.rd_data_valid = rd_valid_q;
    assign sw.wr_overflow   = overflow_q;

endmodule

// File: tb/tb_glb_bank_ctrl.sv
// Directed bench for glb_bank_ctrl with a behavioural single-port SRAM.
module tb_glb_bank_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clear;
    logic        mem_cen;
    logic        mem_wen;
    logic [13:0] mem_addr;
    logic [63:0] mem_data_in;
    logic [63:0] mem_bit_mask;
    logic [63:0] mem_data_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_n = 0;
    int mem_wr_cnt = 0;
    int mem_rd_cnt = 0;
    logic [63:0] resp_data [0:255];
    int          resp_cyc  [0:255];
    logic [63:0] sram      [0:16383];

    always #5 clk = ~clk;

    glb_bank_ctrl_if #(.BANK_ADDR_WIDTH(17), .BANK_DATA_WIDTH(64)) bus ();

    glb_bank_ctrl #(
        .BANK_ADDR_WIDTH(17),
        .BANK_DATA_WIDTH(64),
        .WR_BUF_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(bus),
        .mem_cen(mem_cen),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_bit_mask(mem_bit_mask),
        .mem_data_out(mem_data_out)
    );

    // SRAM model: bit-masked write, registered read data.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16384; i++) sram[i] <= '0;
            mem_data_out <= '0;
        end else if (mem_cen) begin
            if (mem_wen) begin
                sram[mem_addr] <= (sram[mem_addr] & ~mem_bit_mask) | (mem_data_in & mem_bit_mask);
                mem_wr_cnt <= mem_wr_cnt + 1;
            end else begin
                mem_data_out <= sram[mem_addr];
                mem_rd_cnt <= mem_rd_cnt + 1;
            end
        end
    end

    // Edge counter: a read sampled at edge T is expected back when cyc==T+3.
    always @(posedge clk) cyc <= cyc + 1;

    // Response recorder.
    always @(negedge clk) begin
        if (bus.rd_data_valid && resp_n < 256) begin
            resp_data[resp_n] <= bus.rd_data;
            resp_cyc[resp_n]  <= cyc;
            resp_n            <= resp_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic drive(input logic we, input logic [7:0] st, input logic [16:0] wa,
                         input logic [63:0] wd, input logic re, input logic [16:0] ra);
        bus.wr_en   = we;
        bus.wr_strb = st;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b0, 17'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_clear = 1'b1;
        idle(3);
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_data_valid); end
        checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.wr_overflow); end
        checks++; if (mem_cen !== 1'b0) begin errors++; $display("FAIL reset_mem_cen got=%b exp=0", mem_cen); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen got=%b exp=0", mem_wen); end
        checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_data_in !== 64'h0) begin errors++; $display("FAIL reset_mem_data_in got=%h exp=0", mem_data_in); end
        checks++; if (mem_bit_mask !== 64'h0) begin errors++; $display("FAIL reset_mem_bit_mask got=%h exp=0", mem_bit_mask); end
        mem_clear = 1'b0;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_write_read(input logic [16:0] addr, input logic [63:0] data);
        int n0, w0, r0, t;
        n0 = resp_n; w0 = mem_wr_cnt; r0 = mem_rd_cnt;
        drive(1'b1, 8'hFF, addr, data, 1'b0, 17'h0);
        idle(2);
        t = cyc + 1;
        drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, addr);
        idle(5);
        checks++; if (resp_n - n0 !== 1) begin errors++; $display("FAIL wr_rd_count got=%0d exp=1", resp_n - n0); end
        checks++; if (resp_data[n0] !== data) begin errors++; $display("FAIL wr_rd_data got=%h exp=%h", resp_data[n0], data); end
        checks++; if (resp_cyc[n0] !== t + 3) begin errors++; $display("FAIL wr_rd_latency got=%0d exp=%0d", resp_cyc[n0], t + 3); end
        checks++; if (mem_wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr_rd_sram_writes got=%0d exp=1", mem_wr_cnt - w0); end
        checks++; if (mem_rd_cnt - r0 !== 1) begin errors++; $display("FAIL wr_rd_sram_reads got=%0d exp=1", mem_rd_cnt - r0); end
    endtask

    task automatic test_fwd_partial();
        int n0, w0, t;
        drive(1'b1, 8'hFF, 17'h00080, 64'hFFFFFFFF00000000, 1'b0, 17'h0);
        idle(2);
        n0 = resp_n; w0 = mem_wr_cnt; t = cyc + 1;
        drive(1'b1, 8'h0F, 17'h00080, 64'hAAAAAAAABBBBBBBB, 1'b1, 17'h00080);
        idle(1);
        checks++; if ({mem_cen, mem_wen} !== 2'b10) begin errors++; $display("FAIL fwd_read_access got=%b exp=10", {mem_cen, mem_wen}); end
        idle(1);
        checks++; if ({mem_cen, mem_wen} !== 2'b11) begin errors++; $display("FAIL fwd_drain_access got=%b exp=11", {mem_cen, mem_wen}); end
        checks++; if (mem_addr !== 14'h010) begin errors++; $display("FAIL fwd_drain_addr got=%h exp=010", mem_addr); end
        checks++; if (mem_bit_mask !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL fwd_drain_mask got=%h exp=00000000ffffffff", mem_bit_mask); end
        idle(4);
        checks++; if (resp_n - n0 !== 1) begin errors++; $display("FAIL fwd_count got=%0d exp=1", resp_n - n0); end
        checks++; if (resp_data[n0] !== 64'hFFFFFFFFBBBBBBBB) begin errors++; $display("FAIL fwd_data got=%h exp=ffffffffbbbbbbbb", resp_data[n0]); end
        checks++; if (resp_cyc[n0] !== t + 3) begin errors++; $display("FAIL fwd_latency got=%0d exp=%0d", resp_cyc[n0], t + 3); end
        checks++; if (sram[14'h010] !== 64'hFFFFFFFFBBBBBBBB) begin errors++; $display("FAIL fwd_sram got=%h exp=ffffffffbbbbbbbb", sram[14'h010]); end
        checks++; if (mem_wr_cnt - w0 !== 1) begin errors++; $display("FAIL fwd_sram_writes got=%0d exp=1", mem_wr_cnt - w0); end
    endtask

    task automatic test_back_to_back_order();
        int n0, t0, t;
        logic [63:0] exp_rd [4];
        exp_rd[0] = 64'h0102030405060708;
        exp_rd[1] = 64'h0102030405060708;
        exp_rd[2] = 64'h01020304050607EE;
        exp_rd[3] = 64'h01020304050607EE;
        n0 = resp_n; t0 = cyc + 1;
        drive(1'b1, 8'hFF, 17'h00100, 64'h0102030405060708, 1'b1, 17'h00100);
        drive(1'b1, 8'hFF, 17'h00108, 64'h1111111111111111, 1'b1, 17'h00100);
        drive(1'b1, 8'h01, 17'h00100, 64'h00000000000000EE, 1'b1, 17'h00100);
        drive(1'b1, 8'hFF, 17'h00110, 64'h2222222222222222, 1'b1, 17'h00100);
        idle(8);
        checks++; if (resp_n - n0 !== 4) begin errors++; $display("FAIL order_count got=%0d exp=4", resp_n - n0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_data[n0+i] !== exp_rd[i]) begin errors++; $display("FAIL order_data[%0d] got=%h exp=%h", i, resp_data[n0+i], exp_rd[i]); end
            checks++; if (resp_cyc[n0+i] !== t0 + i + 3) begin errors++; $display("FAIL order_latency[%0d] got=%0d exp=%0d", i, resp_cyc[n0+i], t0 + i + 3); end
        end
        checks++; if (sram[14'h020] !== 64'h01020304050607EE) begin errors++; $display("FAIL order_sram_100 got=%h exp=01020304050607ee", sram[14'h020]); end
        checks++; if (sram[14'h021] !== 64'h1111111111111111) begin errors++; $display("FAIL order_sram_108 got=%h exp=1111111111111111", sram[14'h021]); end
        checks++; if (sram[14'h022] !== 64'h2222222222222222) begin errors++; $display("FAIL order_sram_110 got=%h exp=2222222222222222", sram[14'h022]); end
        checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL order_overflow got=%b exp=0", bus.wr_overflow); end
        n0 = resp_n; t = cyc + 1;
        drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, 17'h00100);
        idle(5);
        checks++; if (resp_data[n0] !== 64'h01020304050607EE) begin errors++; $display("FAIL order_reread got=%h exp=01020304050607ee", resp_data[n0]); end
    endtask

    task automatic test_overflow();
        int n0, t0;
        logic [7:0]  b;
        logic [63:0] e;
        n0 = resp_n; t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            b = 8'h10 + 8'(i);
            drive(1'b1, 8'hFF, 17'h00300 + 17'(8 * i), {8{b}}, 1'b1, 17'h00300 + 17'(8 * (i % 4)));
            if (i == 3) begin
                checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", bus.wr_overflow); end
            end
        end
        checks++; if (bus.wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.wr_overflow); end
        idle(8);
        checks++; if (resp_n - n0 !== 10) begin errors++; $display("FAIL ovf_count got=%0d exp=10", resp_n - n0); end
        for (int i = 0; i < 10; i++) begin
            b = 8'h10 + 8'(i % 4);
            e = {8{b}};
            checks++; if (resp_data[n0+i] !== e) begin errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, resp_data[n0+i], e); end
            checks++; if (resp_cyc[n0+i] !== t0 + i + 3) begin errors++; $display("FAIL ovf_latency[%0d] got=%0d exp=%0d", i, resp_cyc[n0+i], t0 + i + 3); end
        end
        for (int j = 0; j < 4; j++) begin
            b = 8'h10 + 8'(j);
            e = {8{b}};
            checks++; if (sram[14'h060 + 14'(j)] !== e) begin errors++; $display("FAIL ovf_sram[%0d] got=%h exp=%h", j, sram[14'h060 + 14'(j)], e); end
        end
        checks++; if (sram[14'h064] !== 64'h0) begin errors++; $display("FAIL ovf_dropped got=%h exp=0", sram[14'h064]); end
        checks++; if (bus.wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.wr_overflow); end
    endtask

    task automatic test_reset_midflight();
        int n0;
        n0 = resp_n;
        drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, 17'h00040);
        drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, 17'h00040);
        drive(1'b0, 8'h00, 17'h0, 64'h0, 1'b1, 17'h00040);
        idle(2);
        reset = 1'b0;
        idle(1);
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", bus.rd_data_valid); end
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL mid_rd_data got=%h exp=0", bus.rd_data); end
        checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", bus.wr_overflow); end
        checks++; if ({mem_cen, mem_wen} !== 2'b00) begin errors++; $display("FAIL mid_mem_ctrl got=%b exp=00", {mem_cen, mem_wen}); end
        checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL mid_mem_addr got=%h exp=0", mem_addr); end
        reset = 1'b1;
        idle(6);
        checks++; if (resp_n - n0 !== 2) begin errors++; $display("FAIL mid_count got=%0d exp=2", resp_n - n0); end
        checks++; if (resp_data[n0] !== 64'h1122334455667788) begin errors++; $display("FAIL mid_data0 got=%h exp=1122334455667788", resp_data[n0]); end
        checks++; if (resp_data[n0+1] !== 64'h1122334455667788) begin errors++; $display("FAIL mid_data1 got=%h exp=1122334455667788", resp_data[n0+1]); end
        test_write_read(17'h00048, 64'hCAFEF00DDEADBEEF);
    endtask

    task automatic test_null_write();
        int a0;
        a0 = mem_wr_cnt + mem_rd_cnt;
        drive(1'b1, 8'h00, 17'h00200, 64'hDEADBEEFDEADBEEF, 1'b0, 17'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_cen !== 1'b0) begin errors++; $display("FAIL null_cen[%0d] got=%b exp=0", i, mem_cen); end
            idle(1);
        end
        checks++; if (mem_wr_cnt + mem_rd_cnt - a0 !== 0) begin errors++; $display("FAIL null_accesses got=%0d exp=0", mem_wr_cnt + mem_rd_cnt - a0); end
        checks++; if (sram[14'h040] !== 64'h0) begin errors++; $display("FAIL null_sram got=%h exp=0", sram[14'h040]); end
        drive(1'b1, 8'hFF, 17'h00208, 64'h5555AAAA5555AAAA, 1'b0, 17'h0);
        idle(1);
        checks++; if ({mem_cen, mem_wen} !== 2'b11) begin errors++; $display("FAIL null_then_bypass got=%b exp=11", {mem_cen, mem_wen}); end
        checks++; if (mem_addr !== 14'h041) begin errors++; $display("FAIL null_bypass_addr got=%h exp=041", mem_addr); end
        idle(3);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_strb = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        test_reset();
        test_write_read(17'h00040, 64'h1122334455667788);
        test_fwd_partial();
        test_back_to_back_order();
        test_overflow();
        test_reset_midflight();
        test_null_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/glb_bank_ctrl.md
Name: glb_bank_ctrl

Overview:
Per-bank memory controller sitting directly downstream of the tile core switch, one instance per bank. It consumes the bank-steered write and read-request packets and drives a single-port SRAM macro. It returns read-response packets at a fixed latency of 3 cycles, which the switch relies on for its response-steering pipeline. Writes that collide with reads are held in a small write buffer, with byte-granular read-after-write forwarding.

Parameters:
BANK_ADDR_WIDTH, 17, byte address width within one bank
BANK_DATA_WIDTH, 64, word width in bits; byte strobe width = BANK_DATA_WIDTH/8
WR_BUF_DEPTH, 4, write buffer entries; power of two, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
wr_en  in  1  write packet valid
wr_strb  in  BANK_DATA_WIDTH/8  byte enables
wr_addr  in  BANK_ADDR_WIDTH  byte address; word index = wr_addr[BANK_ADDR_WIDTH-1:3]
wr_data  in  BANK_DATA_WIDTH  write data
rd_en  in  1  read request valid
rd_addr  in  BANK_ADDR_WIDTH  byte address; word index as for wr_addr
rd_data  out  BANK_DATA_WIDTH  read response data
rd_data_valid  out  1  read response valid
wr_overflow  out  1  sticky error: a write was dropped
mem_cen  out  1  SRAM access enable
mem_wen  out  1  SRAM write (1) or read (0)
mem_addr  out  BANK_ADDR_WIDTH-3  SRAM word address
mem_data_in  out  BANK_DATA_WIDTH  SRAM write data
mem_bit_mask  out  BANK_DATA_WIDTH  per-bit write enable, expanded from byte strobes
mem_data_out  in  BANK_DATA_WIDTH  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset (reset=0 at a clk edge) has the following effects:
  - All outputs go to 0.
  - The write buffer is emptied and wr_overflow is cleared.
  - All in-flight reads are discarded; no rd_data_valid is produced for them.
  - Buffered writes are lost.
- S0 (input register):
  - The write and read packets are registered unconditionally.
  - A write with wr_en=1 and wr_strb=0 is treated as a no-op.
- S1 (SRAM access): exactly one SRAM access per cycle, in this priority order:
  1. A registered read: mem_cen=1, mem_wen=0.
  2. Else the write-buffer head: mem_cen=1, mem_wen=1; the head is popped.
  3. Else the registered write, bypassing the buffer, only when the buffer is empty.
  4. Else mem_cen=0.
- Write ordering:
  - A registered write that is not issued directly in S1 is pushed to the buffer tail.
  - If the buffer is non-empty, a new write is always pushed, never bypassed, so writes are committed in arrival order.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- Buffer full:
  - Full means the buffer holds WR_BUF_DEPTH entries with no pop in this cycle (a read has priority) and a new write arrives.
  - The new write is dropped and wr_overflow is set to 1, held until reset.
  - The buffer contents are unchanged.
- Forwarding (evaluated in S1 for a registered read):
  - Every valid buffer entry is compared against the read word address, as is the write registered in the same cycle.
  - A write presented at S0 in the same cycle as a read is older than that read and is visible to it.
  - For each byte, the youngest matching write wins.
  - The merged byte mask and merged data are registered into S2.
  - A buffer entry popped in the same cycle is still considered.
- S2 (merge): merged byte = forwarded byte where the mask bit is set, else mem_data_out. The result is registered to rd_data and rd_data_valid=1.
- Read latency:
  - A read with rd_en=1 sampled at edge T produces rd_data_valid=1 in the cycle following edge T+3 (3-cycle latency).
  - Reads are fully pipelined: one per cycle, back-to-back, with no bubbles.
- When rd_data_valid=0, rd_data=0.
- Throughput and starvation:
  - Continuous reads starve write drain. This is permitted; loss under that condition is reported only via wr_overflow.
  - A write to the SRAM followed by a read of the same word in the next S1 cycle reads the updated SRAM contents; no forwarding is needed.
- Address wrap: there is none. The word index uses all BANK_ADDR_WIDTH-3 bits, and bits [2:0] are ignored.

Test Plan:
1. Write 0x1122334455667788 to 0x00040 with strb=0xFF. Idle two cycles, then read 0x00040. -> rd_data_valid exactly 3 cycles after rd_en, rd_data=0x1122334455667788; the SRAM saw exactly one write and one read.
2. Same-cycle write to 0x00080 (strb=0x0F, data=0xAAAAAAAABBBBBBBB) and read of 0x00080, with SRAM word previously 0xFFFFFFFF00000000. -> rd_data=0xFFFFFFFFBBBBBBBB; the write is buffered and drained the next idle cycle.
3. Four writes to 0x100, 0x108, 0x100 (strb=0x01, data=0x..EE), 0x110, all coinciding with 4 back-to-back reads of 0x100. -> each later read returns byte0=0xEE; writes drain in order after the reads stop; final SRAM word 0x100 has byte0=0xEE.
4. Read every cycle for 10 cycles while writes arrive every cycle (WR_BUF_DEPTH=4). -> the first 4 writes are buffered, the 5th is dropped, wr_overflow=1 and stays 1; all 10 reads return at 3-cycle latency.
5. Issue 3 reads, then assert reset=0 for one cycle between the 2nd and 3rd responses. -> no further rd_data_valid; all outputs 0; wr_overflow=0; a subsequent write+read sequence behaves as in scenario 1.
6. Write with wr_en=1, strb=0 to 0x200. -> no mem_cen pulse, buffer occupancy unchanged.
